pipeline_sequencer: RTL
=======================

Name: pipeline_sequencer

Overview:
Central run/stall/flush controller for the 5-stage MIPS pipeline. It gates PC and IF/ID register writes, inserts bubbles by dropping the Control decoder's enable, squashes wrong-path instructions on jumps and taken branches, and sequences the halt drain after a decoded `fin`. It also keeps cycle and stall counters for the bench and debug.

Parameters:
DRAIN_CYCLES, 4, cycles of bubbles after `fin` leaves ID until WB is empty; must be >= 1
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse; leaves IDLE
id_ex_memread  in  1  ID/EX stage holds a load
id_ex_rt  in  5  destination register of the ID/EX load
if_id_rs  in  5  rs field of the instruction in IF/ID
if_id_rt  in  5  rt field of the instruction in IF/ID
id_jump  in  1  Control decoded J/JAL/JR/JALR in ID
id_fin  in  1  Control decoded `fin` in ID
ex_branch_taken  in  1  branch resolved taken in EX
pc_write  out  1  PC load enable
if_id_write  out  1  IF/ID load enable
if_id_flush  out  1  clear IF/ID to NOP
ctrl_enable  out  1  drives Control `enable`; 0 means bubble into ID/EX
id_ex_flush  out  1  clear ID/EX control bits
running  out  1  state is RUN or DRAIN
halted  out  1  state is HALT
cycle_count  out  CNT_W  cycles spent in RUN plus DRAIN, saturating
stall_count  out  CNT_W  load-use stall cycles, saturating

Behaviour:
- States: IDLE, RUN, DRAIN, HALT. Reset forces IDLE, drain counter 0, both counters 0.
- Outputs are combinational from state and inputs. State and counters are registered.
- IDLE:
  - pc_write, if_id_write, ctrl_enable, all flushes, running and halted are all 0.
  - start=1 moves to RUN on the next edge.
- RUN defaults: pc_write=1, if_id_write=1, ctrl_enable=1, flushes 0.
- RUN events, highest priority first:
  1. ex_branch_taken: if_id_flush=1, id_ex_flush=1, PC writes the target. Overrides load-use, jump and fin (the wrong-path fin is squashed). No state change.
  2. id_jump: if_id_flush=1, pc/if_id writes stay 1.
  3. load-use: id_ex_memread and id_ex_rt!=0 and (id_ex_rt==if_id_rs or id_ex_rt==if_id_rt). Then pc_write=0, if_id_write=0, ctrl_enable=0. stall_count +1. Stall lasts exactly one cycle per hazard occurrence.
  4. id_fin: pc_write=0, if_id_write=0, ctrl_enable stays 1 this cycle. Next state DRAIN; drain counter loads DRAIN_CYCLES-1.
- DRAIN:
  - pc_write=0, if_id_write=0, ctrl_enable=0, flushes 0, running=1.
  - Counter decrements each cycle; at 0 the next state is HALT. Total DRAIN dwell is exactly DRAIN_CYCLES.
  - All data inputs are ignored.
- HALT:
  - All write/enable/flush outputs 0, running=0, halted=1.
  - start is ignored; the only exit is reset.
- start in RUN or DRAIN is ignored.
- cycle_count increments every cycle the state is RUN or DRAIN; stall_count increments per load-use cycle. Both saturate at all-ones.
- reset_n asserted mid-operation: immediate return to IDLE with all outputs at IDLE values and counters cleared, regardless of drain progress.

Decomposition:
- Package pipe_ctrl_pkg:
  - state enum encoding (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, HALT=2'd3)
  - REG_ZERO=5'd0
- Sub-module hazard_detect: purely combinational load-use compare (id_ex_memread, id_ex_rt, if_id_rs, if_id_rt -> load_use). It is reused by the forwarding work.

Test Plan:
1. Reset then start pulse at cycle 2 -> IDLE outputs all 0 through cycle 2; RUN from cycle 3 with pc_write=1, ctrl_enable=1; cycle_count=1 at cycle 4.
2. id_ex_memread=1, id_ex_rt=8, if_id_rs=8 for one cycle -> pc_write=0, if_id_write=0, ctrl_enable=0 that cycle; stall_count=1. The same with id_ex_rt=0 -> no stall.
3. ex_branch_taken=1 together with a load-use match and id_fin=1 -> if_id_flush=1, id_ex_flush=1, pc_write=1; no stall count, state stays RUN.
4. id_jump=1 alone -> if_id_flush=1, id_ex_flush=0, pc_write=1.
5. id_fin=1 with DRAIN_CYCLES=4 -> pc_write=0 that cycle; DRAIN for exactly 4 cycles with ctrl_enable=0; halted=1 on the 5th cycle; a later start keeps halted=1.
6. reset_n low during DRAIN cycle 2 -> immediately IDLE, counters 0, halted=0; a new start resumes RUN.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline run/stall/flush controller.
package pipe_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the ID/EX load and the IF/ID source fields.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       id_ex_memread,
  input  logic [4:0] id_ex_rt,
  input  logic [4:0] if_id_rs,
  input  logic [4:0] if_id_rt,
  output logic       load_use
);

  // A load into $zero never creates a real dependency.
  always_comb begin
    load_use = id_ex_memread && (id_ex_rt != REG_ZERO) &&
               ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Run/stall/flush/halt-drain controller for the 5-stage pipeline, with
// saturating cycle and stall counters.
module pipeline_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rt,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic             id_jump,
  input  logic             id_fin,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             ctrl_enable,
  output logic             id_ex_flush,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

  logic [1:0]         state_q;
  logic [1:0]         state_d;
  logic [DRAIN_W-1:0] drain_q;
  logic [DRAIN_W-1:0] drain_d;
  logic               load_use;
  logic               stall_inc;
  logic               cycle_inc;

  hazard_detect u_hazard_detect (
    .id_ex_memread (id_ex_memread),
    .id_ex_rt      (id_ex_rt),
    .if_id_rs      (if_id_rs),
    .if_id_rt      (if_id_rt),
    .load_use      (load_use)
  );

  // State and drain counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Next-state and pipeline control decode; branch beats jump beats load-use beats fin.
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    ctrl_enable = 1'b0;
    id_ex_flush = 1'b0;
    running     = 1'b0;
    halted      = 1'b0;
    stall_inc   = 1'b0;
    cycle_inc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        running     = 1'b1;
        cycle_inc   = 1'b1;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        ctrl_enable = 1'b1;
        if (ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (id_jump) begin
          if_id_flush = 1'b1;
        end else if (load_use) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          ctrl_enable = 1'b0;
          stall_inc   = 1'b1;
        end else if (id_fin) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          state_d     = ST_DRAIN;
          drain_d     = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        running   = 1'b1;
        cycle_inc = 1'b1;
        if (drain_q == '0) begin
          state_d = ST_HALT;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_count <= '0;
      stall_count <= '0;
    end else begin
      if (cycle_inc && (cycle_count != '1)) cycle_count <= cycle_count + CNT_W'(1);
      if (stall_inc && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule
